x_ctrl_hazard: RTL and testbench

Execute-stage control for the pipelined RV32I core, generalising the fixed X-stage select logic. It produces operand-forwarding selects from a parametrised-depth history of in-flight destinations, operand source selects, and branch/jump resolution. It also adds a load-use stall counter and a multi-cycle flush sequencer. It sits between the D/X pipeline register and the X-stage datapath muxes, ALU and branch comparator.

---
 rtl/x_ctrl_hazard_pkg.sv | 59 +++++
 rtl/x_ctrl_hazard_fwd_history.sv | 49 ++++
 rtl/x_ctrl_hazard.sv | 155 +++++++++++++++
 tb/tb_x_ctrl_hazard.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/x_ctrl_hazard_pkg.sv
// Shared RV32I decode constants and types for the X-stage control block.
// Operand-use helpers are shared so X-side forwarding and D-side load-use use the same rules.
package x_ctrl_hazard_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam int CNT_W = 2;

   typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_e;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       is_load;
   } hist_ent_t;

   function automatic logic writes_rd(input logic [6:0] opc);
      logic r;
      case (opc)
         OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JAL, OPC_JALR,
         OPC_LUI, OPC_AUIPC, OPC_SYSTEM: r = 1'b1;
         default:                        r = 1'b0;
      endcase
      return r;
   endfunction

   // CSR register forms (funct3 001/010/011) read rs1; immediate forms reuse the field as uimm.
   function automatic logic reads_rs1(input logic [6:0] opc, input logic [2:0] f3);
      logic r;
      case (opc)
         OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE,
         OPC_BRANCH, OPC_JALR: r = 1'b1;
         OPC_SYSTEM:           r = !f3[2] && (f3 != 3'b000);
         default:              r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic reads_rs2(input logic [6:0] opc);
      return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/x_ctrl_hazard_fwd_history.sv
// Shift register of in-flight destinations plus nearest-first match for rs1/rs2.
// Entry 1 is the instruction one stage older than X.
module x_fwd_history
   import x_ctrl_hazard_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int SEL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  hist_ent_t        push_ent,
   input  logic             rs1_en,
   input  logic [4:0]       rs1,
   input  logic             rs2_en,
   input  logic [4:0]       rs2,
   output logic [SEL_W-1:0] sel1,
   output logic [SEL_W-1:0] sel2
);

   hist_ent_t [DEPTH:1] ent_q, ent_d;
   logic                unused_ld;

   always_comb begin
      ent_d    = ent_q;
      ent_d[1] = push_ent;
      for (int k = 2; k <= DEPTH; k++) ent_d[k] = ent_q[k-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ent_q <= '0;
      else       ent_q <= ent_d;
   end

   // Walk oldest to newest so the nearest match overwrites older ones.
   always_comb begin
      sel1 = '0;
      sel2 = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (rs1_en && ent_q[k].vld && ent_q[k].rd == rs1) sel1 = SEL_W'(k);
         if (rs2_en && ent_q[k].vld && ent_q[k].rd == rs2) sel2 = SEL_W'(k);
      end
   end

   always_comb begin
      unused_ld = 1'b0;
      for (int k = 1; k <= DEPTH; k++) unused_ld = unused_ld ^ ent_q[k].is_load;
   end

endmodule

// File: rtl/x_ctrl_hazard.sv
// Execute-stage control: forwarding selects, operand selects, branch resolution,
// load-use stall and post-redirect flush sequencing.
module x_ctrl_hazard
   import x_ctrl_hazard_pkg::*;
#(
   parameter  int FWD_DEPTH    = 2,
   parameter  int LOAD_LAT     = 1,
   parameter  int FLUSH_CYCLES = 1,
   localparam int FSEL_W       = $clog2(FWD_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              x_valid,
   input  logic [31:0]       x_inst,
   input  logic [31:0]       d_inst,
   input  logic              br_eq,
   input  logic              br_lt,
   output logic [FSEL_W-1:0] fwd_a,
   output logic [FSEL_W-1:0] fwd_b,
   output logic              a_pc,
   output logic              b_imm,
   output logic              br_un,
   output logic              pc_sel,
   output logic              dmem_re,
   output logic              mem_we,
   output logic              stall,
   output logic              flush
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [6:0] opc, d_opc;
   logic [2:0] f3, d_f3;
   logic [4:0] rd;
   logic       x_eff, is_br, is_load, taken, ld_hit;
   logic       rs1_en, rs2_en;
   hist_ent_t  push_ent;
   logic       unused_bits;

   assign opc   = x_inst[6:0];
   assign rd    = x_inst[11:7];
   assign f3    = x_inst[14:12];
   assign d_opc = d_inst[6:0];
   assign d_f3  = d_inst[14:12];
   assign unused_bits = ^{x_inst[31:25], d_inst[31:25], d_inst[11:7]};

   // Wrong-path instructions during FLUSH and everything under reset act as bubbles.
   assign x_eff   = x_valid && (state_q != ST_FLUSH) && !reset;
   assign is_br   = (opc == OPC_BRANCH);
   assign is_load = (opc == OPC_LOAD);

   always_comb begin
      taken = 1'b0;
      case (f3)
         F3_BEQ:           taken = br_eq;
         F3_BNE:           taken = !br_eq;
         F3_BLT, F3_BLTU:  taken = br_lt;
         F3_BGE, F3_BGEU:  taken = !br_lt;
         default:          taken = 1'b0;
      endcase
   end

   always_comb begin
      a_pc    = x_eff && (is_br || opc == OPC_JAL || opc == OPC_AUIPC);
      b_imm   = x_eff && (opc != OPC_OP);
      br_un   = x_eff && is_br && (f3[2:1] == 2'b11);
      pc_sel  = x_eff && ((is_br && taken) || opc == OPC_JAL || opc == OPC_JALR);
      dmem_re = x_eff && is_load;
      mem_we  = x_eff && (opc == OPC_STORE);
   end

   always_comb begin
      push_ent.vld     = x_eff && writes_rd(opc) && (rd != 5'd0);
      push_ent.rd      = rd;
      push_ent.is_load = is_load;
      rs1_en = x_eff && reads_rs1(opc, f3);
      rs2_en = x_eff && reads_rs2(opc);
   end

   x_fwd_history #(
      .DEPTH (FWD_DEPTH),
      .SEL_W (FSEL_W)
   ) u_hist (
      .clk      (clk),
      .reset    (reset),
      .push_ent (push_ent),
      .rs1_en   (rs1_en),
      .rs1      (x_inst[19:15]),
      .rs2_en   (rs2_en),
      .rs2      (x_inst[24:20]),
      .sel1     (fwd_a),
      .sel2     (fwd_b)
   );

   assign ld_hit = x_eff && (state_q == ST_RUN) && is_load && (rd != 5'd0) &&
                   ((reads_rs1(d_opc, d_f3) && d_inst[19:15] == rd) ||
                    (reads_rs2(d_opc)       && d_inst[24:20] == rd));

   // A redirect kills D, so a pending hazard on it no longer needs a stall.
   assign flush = !reset && (pc_sel || state_q == ST_FLUSH);
   assign stall = !reset && !flush && (state_q == ST_STALL || ld_hit);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (pc_sel) begin
               if (FLUSH_CYCLES > 1) begin
                  state_d = ST_FLUSH;
                  cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
               end
            end else if (ld_hit && LOAD_LAT > 1) begin
               state_d = ST_STALL;
               cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
         end
         ST_STALL: begin
            if (pc_sel && FLUSH_CYCLES > 1) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end else if (pc_sel || cnt_q <= CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_FLUSH: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_x_ctrl_hazard.sv
// Directed vector bench for x_ctrl_hazard with FWD_DEPTH=2, LOAD_LAT=2, FLUSH_CYCLES=3.
module tb_x_ctrl_hazard;

   logic        clk, reset, x_valid, br_eq, br_lt;
   logic [31:0] x_inst, d_inst;
   logic [1:0]  fwd_a, fwd_b;
   logic        a_pc, b_imm, br_un, pc_sel, dmem_re, mem_we, stall, flush;
   logic [11:0] outs;

   int n_vec = 0;
   int n_err = 0;

   x_ctrl_hazard #(.FWD_DEPTH(2), .LOAD_LAT(2), .FLUSH_CYCLES(3)) dut (
      .clk(clk), .reset(reset), .x_valid(x_valid), .x_inst(x_inst), .d_inst(d_inst),
      .br_eq(br_eq), .br_lt(br_lt), .fwd_a(fwd_a), .fwd_b(fwd_b), .a_pc(a_pc),
      .b_imm(b_imm), .br_un(br_un), .pc_sel(pc_sel), .dmem_re(dmem_re),
      .mem_we(mem_we), .stall(stall), .flush(flush)
   );

   assign outs = {fwd_a, fwd_b, a_pc, b_imm, br_un, pc_sel, dmem_re, mem_we, stall, flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        xv;
      logic [31:0] xi;
      logic [31:0] di;
      logic        eq;
      logic        lt;
      logic [11:0] e;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] enc_i(logic [6:0] opc, logic [2:0] f3, logic [4:0] rd,
                                         logic [4:0] rs1, logic [11:0] imm);
      return {imm, rs1, f3, rd, opc};
   endfunction
   function automatic logic [31:0] enc_r(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_s(logic [4:0] rs2, logic [4:0] rs1);
      return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2);
      return {7'b0, rs2, rs1, f3, 5'b0, 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(logic [4:0] rd);
      return {20'b0, rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
      return enc_i(7'b0010011, 3'b000, rd, rs1, imm);
   endfunction
   function automatic logic [31:0] lw(logic [4:0] rd, logic [4:0] rs1);
      return enc_i(7'b0000011, 3'b010, rd, rs1, 12'd0);
   endfunction

   // Expected outputs: fwd_a, fwd_b, a_pc, b_imm, br_un, pc_sel, dmem_re, mem_we, stall, flush
   function automatic logic [11:0] o(int fa, int fb, logic apc, logic bimm, logic bun,
                                     logic psel, logic re, logic we, logic st, logic fl);
      return {2'(fa), 2'(fb), apc, bimm, bun, psel, re, we, st, fl};
   endfunction

   task automatic av(input logic xv, input logic [31:0] xi, input logic [31:0] di,
                     input logic eq, input logic lt, input logic [11:0] e);
      vec_t v;
      v.xv = xv; v.xi = xi; v.di = di; v.eq = eq; v.lt = lt; v.e = e;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [11:0] exp);
      n_vec++;
      if (outs !== exp) begin
         n_err++;
         $display("FAIL %s got=%b want=%b (fa fb apc bimm bun psel re we st fl)", nm, outs, exp);
      end
   endtask

   task automatic drive(input logic xv, input logic [31:0] xi, input logic [31:0] di,
                        input logic eq, input logic lt);
      x_valid = xv; x_inst = xi; d_inst = di; br_eq = eq; br_lt = lt;
   endtask

   initial begin
      logic [31:0] nop, dep;
      nop = addi(5'd0, 5'd0, 12'd0);
      dep = enc_r(5'd9, 5'd8, 5'd2);

      // forwarding chain
      av(1, addi(5, 0, 7),        nop, 0, 0, o(0,0,0,1,0,0,0,0,0,0));
      av(1, addi(6, 0, 3),        nop, 0, 0, o(0,0,0,1,0,0,0,0,0,0));
      av(1, enc_r(7, 5, 6),       nop, 0, 0, o(2,1,0,0,0,0,0,0,0,0));
      av(1, enc_r(9, 0, 0),       nop, 0, 0, o(0,0,0,0,0,0,0,0,0,0));
      av(1, enc_s(7, 9),          nop, 0, 0, o(1,2,0,1,0,0,0,1,0,0));
      av(0, enc_r(9, 9, 9),       nop, 0, 0, o(0,0,0,0,0,0,0,0,0,0));
      // load-use, two stall cycles then forward from stage 2
      av(1, lw(8, 1),             dep, 0, 0, o(0,0,0,1,0,0,1,0,1,0));
      av(0, nop,                  dep, 0, 0, o(0,0,0,0,0,0,0,0,1,0));
      av(1, dep,                  nop, 0, 0, o(2,0,0,0,0,0,0,0,0,0));
      // beq taken, flush for 3 cycles, wrong-path ops suppressed
      av(1, enc_b(3'b000, 9, 9),  nop, 1, 0, o(1,1,1,1,0,1,0,0,0,1));
      av(1, enc_r(3, 9, 9),       nop, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
      av(1, enc_s(3, 3),          nop, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
      av(1, enc_b(3'b101, 1, 2),  nop, 0, 1, o(0,0,1,1,0,0,0,0,0,0));
      av(1, enc_b(3'b110, 1, 2),  nop, 0, 1, o(0,0,1,1,1,1,0,0,0,1));
      av(0, nop,                  nop, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
      av(0, nop,                  nop, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
      // jal flush; addi x10 in the shadow must not reach history
      av(1, enc_j(1),             nop, 0, 0, o(0,0,1,1,0,1,0,0,0,1));
      av(1, addi(10, 1, 1),       nop, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
      av(1, enc_s(10, 10),        nop, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
      av(1, enc_r(11, 10, 10),    nop, 0, 0, o(0,0,0,0,0,0,0,0,0,0));
      // taken branch while a load-use stall is pending: flush wins
      av(1, lw(8, 1),             dep, 0, 0, o(0,0,0,1,0,0,1,0,1,0));
      av(1, enc_b(3'b000, 0, 0),  dep, 1, 0, o(0,0,1,1,0,1,0,0,0,1));
      av(0, nop,                  nop, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
      av(0, nop,                  nop, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
      // boundaries: load to x0, illegal branch funct3, bgeu not taken
      av(1, lw(0, 1),             enc_r(9, 0, 0), 0, 0, o(0,0,0,1,0,0,1,0,0,0));
      av(1, enc_b(3'b010, 1, 2),  nop, 1, 1, o(0,0,1,1,0,0,0,0,0,0));
      av(1, enc_b(3'b111, 1, 2),  nop, 0, 1, o(0,0,1,1,1,0,0,0,0,0));

      reset = 1'b1;
      drive(1, addi(5, 0, 7), nop, 1, 1);
      #3 chk("reset", o(0,0,0,0,0,0,0,0,0,0));
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].xv, vq[i].xi, vq[i].di, vq[i].eq, vq[i].lt);
         #2 chk($sformatf("vec%0d", i), vq[i].e);
         @(posedge clk); #1;
      end

      // reset asserted in the second stall cycle
      drive(1, lw(8, 1), dep, 0, 0);
      #2 chk("rst_ld", o(0,0,0,1,0,0,1,0,1,0));
      @(posedge clk); #1;
      drive(1, enc_s(8, 8), dep, 0, 0);
      #1 chk("rst_stall2", o(1,1,0,1,0,0,0,1,1,0));
      reset = 1'b1;
      #1 chk("rst_mid", o(0,0,0,0,0,0,0,0,0,0));
      reset = 1'b0;
      #1 chk("rst_rel", o(0,0,0,1,0,0,0,1,0,0));
      @(posedge clk); #1;
      drive(1, dep, nop, 0, 0);
      #2 chk("rst_after", o(0,0,0,0,0,0,0,0,0,0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
